// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit SRAM with configurable wait states.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_valid,
  input  logic [31:0]                  m0_addr,
  input  logic [31:0]                  m0_wdata,
  input  logic [3:0]                   m0_wstrb,
  output logic                         m0_ready,
  output logic [31:0]                  m0_rdata,
  input  logic                         m1_valid,
  input  logic [31:0]                  m1_addr,
  input  logic [31:0]                  m1_wdata,
  input  logic [3:0]                   m1_wstrb,
  output logic                         m1_ready,
  output logic [31:0]                  m1_rdata,
  output logic                         sram_en,
  output logic [3:0]                   sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata,
  output logic                         err_oor
);

  localparam int         AW        = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state;
  logic        gnt;
  logic        is_wr;
  logic        oor_q;
  logic [3:0]  wait_cnt;
`ifdef MEM_ARBITER_RR_EN
  logic        rr_ptr;
`endif

  logic        gnt_nxt;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        oor_nxt;
  logic        unused_addr_lsb;

  // Arbitration and request mux, evaluated only while idle
  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    gnt_nxt = m0_valid ? (m1_valid ? rr_ptr : 1'b0) : 1'b1;
`else
    gnt_nxt = !m0_valid;
`endif
    sel_addr  = gnt_nxt ? m1_addr  : m0_addr;
    sel_wdata = gnt_nxt ? m1_wdata : m0_wdata;
    sel_wstrb = gnt_nxt ? m1_wstrb : m0_wstrb;
    oor_nxt   = |sel_addr[31:AW+2];
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt        <= 1'b0;
      is_wr      <= 1'b0;
      oor_q      <= 1'b0;
      wait_cnt   <= 4'd0;
      sram_en    <= 1'b0;
      sram_we    <= 4'h0;
      sram_addr  <= '0;
      sram_wdata <= 32'h0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_rdata   <= 32'h0;
      m1_rdata   <= 32'h0;
      err_oor    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_valid || m1_valid) begin
            gnt        <= gnt_nxt;
            is_wr      <= |sel_wstrb;
            oor_q      <= oor_nxt;
            sram_addr  <= sel_addr[AW+1:2];
            sram_wdata <= sel_wdata;
            sram_en    <= !oor_nxt;
            sram_we    <= oor_nxt ? 4'h0 : sel_wstrb;
`ifdef MEM_ARBITER_RR_EN
            rr_ptr     <= !gnt_nxt;
`endif
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          sram_en <= 1'b0;
          sram_we <= 4'h0;
          if (WAIT_CYCLES == 0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          // First RESP edge raises ready; the second drops it and returns to idle
          if (!(m0_ready || m1_ready)) begin
            m0_ready <= !gnt;
            m1_ready <= gnt;
            err_oor  <= oor_q;
            if (oor_q || !is_wr) begin
              if (gnt) m1_rdata <= oor_q ? 32'h0 : sram_rdata;
              else     m0_rdata <= oor_q ? 32'h0 : sram_rdata;
            end
          end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            err_oor  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
